// File: rtl/event_pack_and_stream.sv
// Packs 32x16-bit AXI-Stream samples into 12-bit fields and streams them as
// SURF-ordered 64-bit words; PACK_DATA="FALSE" passes the raw beat as 8 words.
module event_pack_and_stream #(
  parameter string PACK_DATA = "TRUE"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  input  logic [63:0]  s_axis_tkeep,
  output logic [63:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         msb_err_o
);

  localparam bit         PACK     = (PACK_DATA == "TRUE");
  localparam int         NW       = PACK ? 6 : 8;
  localparam int         HW       = PACK ? 384 : 512;
  localparam logic [2:0] LAST_IDX = 3'(NW - 1);

  logic [HW-1:0] hold;
  logic [HW-1:0] load;
  logic          hold_valid;
  logic          hold_last;
  logic [2:0]    widx;
  logic          msb_err;
  logic [63:0]   sel_word;
  logic          msb_any;
  logic          last_word;
  logic          m_hs;
  logic          s_hs;
  logic          unused_keep;

  // tkeep carries no information: the producer always drives all ones.
  assign unused_keep = ^s_axis_tkeep;

  assign last_word     = (widx == LAST_IDX);
  assign m_axis_tvalid = hold_valid;
  assign m_hs          = hold_valid && m_axis_tready;
  assign s_axis_tready = !rst && (!hold_valid || (m_axis_tready && last_word));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tlast  = hold_valid && hold_last && last_word;
  assign msb_err_o     = msb_err;

  always_comb begin
    msb_any = 1'b0;
    for (int i = 0; i < 32; i++) begin
      msb_any = msb_any | (|s_axis_tdata[16*i+12 +: 4]);
    end
  end

  generate
    if (PACK) begin : g_pack
      always_comb begin
        load = '0;
        for (int i = 0; i < 32; i++) begin
          load[12*i +: 12] = s_axis_tdata[16*i +: 12];
        end
      end

      // Lower 192-bit half first; within a half, the top 64 bits go first.
      always_comb begin
        case (widx)
          3'd0:    sel_word = hold[128 +: 64];
          3'd1:    sel_word = hold[64 +: 64];
          3'd2:    sel_word = hold[0 +: 64];
          3'd3:    sel_word = hold[320 +: 64];
          3'd4:    sel_word = hold[256 +: 64];
          default: sel_word = hold[192 +: 64];
        endcase
      end

      // Inverse of the receive-side SURF remap.
      always_comb begin
        m_axis_tdata          = '0;
        m_axis_tdata[56 +: 8] = sel_word[0 +: 8];
        m_axis_tdata[48 +: 4] = sel_word[8 +: 4];
        m_axis_tdata[52 +: 4] = sel_word[12 +: 4];
        m_axis_tdata[40 +: 8] = sel_word[16 +: 8];
        m_axis_tdata[32 +: 8] = sel_word[24 +: 8];
        m_axis_tdata[24 +: 4] = sel_word[32 +: 4];
        m_axis_tdata[28 +: 4] = sel_word[36 +: 4];
        m_axis_tdata[16 +: 8] = sel_word[40 +: 8];
        m_axis_tdata[8 +: 8]  = sel_word[48 +: 8];
        m_axis_tdata[0 +: 4]  = sel_word[56 +: 4];
        m_axis_tdata[4 +: 4]  = sel_word[60 +: 4];
      end
    end else begin : g_raw
      assign load         = s_axis_tdata;
      assign sel_word     = hold[{widx, 6'b0} +: 64];
      assign m_axis_tdata = sel_word;
    end
  endgenerate

  // A load on the final-word handshake overrides the clear, so beats are gapless.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      widx       <= 3'd0;
      msb_err    <= 1'b0;
    end else begin
      if (m_hs) begin
        if (last_word) begin
          widx       <= 3'd0;
          hold_valid <= 1'b0;
        end else begin
          widx <= widx + 3'd1;
        end
      end
      if (s_hs) begin
        hold       <= load;
        hold_valid <= 1'b1;
        hold_last  <= s_axis_tlast;
        widx       <= 3'd0;
      end
      if (s_hs && msb_any) begin
        msb_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/event_pack_and_stream.md
# event_pack_and_stream

Transmit-side counterpart of the event expand-and-store path. It accepts 512-bit AXI4-Stream beats of 32 zero-extended 16-bit samples, truncates each sample to 12 bits, and packs the 384-bit result into six 64-bit words. Each word is emitted in the SURF wire ordering, which is the exact inverse of the receive-side remap. Its output feeds the 64-bit event payload link, so a stream round-trips bit-exactly through the expander.

## Interface
- PACK_DATA, "TRUE", "TRUE": 12-bit pack, 6 words per beat; "FALSE": raw 512 to 8 words, no truncation or remap.
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  512  32 samples; sample i at [16i +: 16]
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when tvalid && tready
- s_axis_tlast  in  1  last beat of event
- s_axis_tkeep  in  64  ignored; producer drives all ones
- m_axis_tdata  out  64  packed SURF-order word
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  downstream accept
- m_axis_tlast  out  1  last word of event
- msb_err_o  out  1  sticky: some accepted sample had nonzero bits [15:12]

## Operation
- Holding register `hold`: 384 bits, or 512 bits when PACK_DATA="FALSE". Companion state:
  - `hold_valid`
  - `hold_last`
  - 3-bit word index `widx`; the final index `NW-1` is 5 for "TRUE" and 7 for "FALSE".
- Load, PACK_DATA="TRUE": `hold[12i +: 12] = s_axis_tdata[16i +: 12]` for i=0..31.
- If any sample has [15:12] != 0 on an accepted beat, set `msb_err_o`. It clears only on rst.
- Word select, "TRUE": H0 = hold[0 +: 192] is sent first, then H1 = hold[192 +: 192]. Within each half Hk, words go out in the order Hk[128 +: 64], Hk[64 +: 64], Hk[0 +: 64].
- Inverse remap applied to each selected word r to give output d:
  - d[56+:8] = r[0+:8]
  - d[48+:4] = r[8+:4]
  - d[52+:4] = r[12+:4]
  - d[40+:8] = r[16+:8]
  - d[32+:8] = r[24+:8]
  - d[24+:4] = r[32+:4]
  - d[28+:4] = r[36+:4]
  - d[16+:8] = r[40+:8]
  - d[8+:8] = r[48+:8]
  - d[0+:4] = r[56+:4]
  - d[4+:4] = r[60+:4]
- PACK_DATA="FALSE": word w = s_axis_tdata[64w +: 64], sent w=0..7, with no remap.
- tlast: `m_axis_tlast = hold_last && (widx == NW-1)`. It is never asserted on any other word.
- Handshake rules:
  - `widx` advances on each m_axis handshake.
  - On the handshake of word NW-1, `widx` returns to 0 and `hold_valid` clears unless a new beat loads in the same cycle.
  - `s_axis_tready = !hold_valid || (m_axis_tvalid && m_axis_tready && widx == NW-1)`. This gives gapless back-to-back beats.
- `m_axis_tvalid = hold_valid`. While `m_axis_tvalid && !m_axis_tready`, `m_axis_tdata` and `m_axis_tlast` hold stable.

## Timing
- Reset values:
  - `s_axis_tready` = 0 while rst is high, and 1 on the first cycle after.
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - `msb_err_o` = 0, `widx` = 0.
- Latency: an input accepted at edge N gives its first output word valid after edge N (one cycle).
- Throughput with m_axis_tready held high: one input beat per NW cycles, and m_axis_tvalid stays continuously high.
- Simultaneous events: a last-word handshake and a new-beat load in the same cycle perform the load with `widx` = 0. There is no bubble.
- rst mid-beat discards the partial beat. No tlast is emitted for it, and the next word out after reset is word 0 of a new beat.
- Downstream stall: words are never dropped or duplicated, and `s_axis_tready` stays 0 until the final word handshakes.

## Test plan
- Single beat, sample 0 = 0xFFF, all other samples 0, tlast=1, tready high:
  - Exactly 6 words out, on the consecutive cycles starting one cycle after acceptance.
  - Word 2 (0-based) = 0xFF0F000000000000; all other words = 0.
  - tlast is asserted only on word 5.
- Single beat, sample 31 = 0xFFF, all others 0: word 3 = 0x000000000000F0FF, all others 0, `msb_err_o` stays 0.
- Round-trip: 48 beats of random 12-bit samples with tlast on beat 47, random m_axis_tready (50%), fed into event_expand_and_store:
  - All 48 beats reproduced bit-exactly, with tlast on beat 47.
  - No beat is lost or duplicated under stall.
- Back-to-back: s_axis_tvalid held high for 4 beats, m_axis_tready high:
  - 24 contiguous valid words.
  - s_axis_tready pulses once per 6 cycles, coincident with word 5.
- Beat with sample 7 = 0x1ABC: `msb_err_o` rises after acceptance and stays high until rst. Output carries 0xABC in that sample's slot.
- rst asserted after word 2 of a beat:
  - m_axis_tvalid = 0 the cycle after rst.
  - The next beat's words start at word 0 with correct data.
  - PACK_DATA="FALSE" variant: s_axis_tdata = {8 words} yields those 8 words low-first, unmodified.
